adder_16_bit_arbiter: RTL

- Shares one adder_16_bit instance between two independent requesters using valid/ready handshakes and round-robin arbitration.
- Each accepted operation goes through a fixed sequence: operand capture, execute, and registered response.
- Per-requester saturating operation counters provide debug visibility.
- Sits between client blocks and the shared adder datapath. Only one operation is in flight at any time.

---
 rtl/adder_16_bit_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/adder_16_bit_arbiter.sv
// Two-port round-robin front end for one shared 16-bit adder.
// Each operation runs capture -> execute -> registered response; counters track completions.

module adder_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bit
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
    end
  endgenerate

  assign cout = carry[16];

endmodule

module adder_16_bit_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [15:0]      rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [15:0]      rsp1_sum,
  output logic             rsp1_cout,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_reg;
  logic              last_grant_reg;
  logic              grant_id_reg;
  logic [15:0]       a_reg;
  logic [15:0]       b_reg;
  logic              cin_reg;
  logic [16:0]       result_reg;
  logic              rsp_loaded_reg;
  logic              rsp0_valid_reg;
  logic              rsp1_valid_reg;
  logic [15:0]       rsp0_sum_reg;
  logic [15:0]       rsp1_sum_reg;
  logic              rsp0_cout_reg;
  logic              rsp1_cout_reg;
  logic [CNT_W-1:0]  cnt0_reg;
  logic [CNT_W-1:0]  cnt1_reg;

  logic              grant_any;
  logic              grant;
  logic              accept;
  logic              rsp_done;
  logic [15:0]       add_sum;
  logic              add_cout;

  // Tie goes to whichever requester was not served last.
  assign grant_any = req0_valid | req1_valid;
  assign grant     = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
  assign accept    = (state_reg == IDLE) && grant_any && !rst;

  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;

  assign rsp_done = rsp_loaded_reg && (grant_id_reg ? rsp1_ready : rsp0_ready);

  adder_16_bit u_adder (
    .a    (a_reg),
    .b    (b_reg),
    .cin  (cin_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_id_reg   <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      cin_reg        <= 1'b0;
      result_reg     <= '0;
      rsp_loaded_reg <= 1'b0;
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
      rsp0_sum_reg   <= '0;
      rsp1_sum_reg   <= '0;
      rsp0_cout_reg  <= 1'b0;
      rsp1_cout_reg  <= 1'b0;
      cnt0_reg       <= '0;
      cnt1_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            a_reg          <= grant ? req1_a   : req0_a;
            b_reg          <= grant ? req1_b   : req0_b;
            cin_reg        <= grant ? req1_cin : req0_cin;
            grant_id_reg   <= grant;
            last_grant_reg <= grant;
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          result_reg     <= {add_cout, add_sum};
          rsp_loaded_reg <= 1'b0;
          state_reg      <= RESP;
        end
        RESP: begin
          // First RESP cycle moves the result into the per-port output registers;
          // the port's outputs stay untouched while another requester is served.
          if (!rsp_loaded_reg) begin
            rsp_loaded_reg <= 1'b1;
            if (grant_id_reg) begin
              rsp1_sum_reg   <= result_reg[15:0];
              rsp1_cout_reg  <= result_reg[16];
              rsp1_valid_reg <= 1'b1;
            end else begin
              rsp0_sum_reg   <= result_reg[15:0];
              rsp0_cout_reg  <= result_reg[16];
              rsp0_valid_reg <= 1'b1;
            end
          end else if (rsp_done) begin
            rsp_loaded_reg <= 1'b0;
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            state_reg      <= IDLE;
            if (grant_id_reg) begin
              if (cnt1_reg != CNT_MAX) cnt1_reg <= cnt1_reg + CNT_ONE;
            end else begin
              if (cnt0_reg != CNT_MAX) cnt0_reg <= cnt0_reg + CNT_ONE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp0_valid = rsp0_valid_reg;
  assign rsp1_valid = rsp1_valid_reg;
  assign rsp0_sum   = rsp0_sum_reg;
  assign rsp1_sum   = rsp1_sum_reg;
  assign rsp0_cout  = rsp0_cout_reg;
  assign rsp1_cout  = rsp1_cout_reg;
  assign busy       = (state_reg != IDLE);
  assign cnt0       = cnt0_reg;
  assign cnt1       = cnt1_reg;

endmodule
